dmem_lsu_ctrl: RTL and testbench
================================

// Module: dmem_lsu_ctrl
// PURPOSE
//  Load/store sequencer in front of the word-only data memory (1 KiW, combinational read, write on clock edge).
//  Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW from the execute stage over a valid/ready request and one-cycle response.
//  Sub-word stores are done as read-modify-write; loads are byte/halfword extracted and sign/zero extended.
//  Detects misaligned, out-of-range and illegal-funct3 accesses without touching memory.
// PARAMETERS
//  MEM_ADDR_BITS  12  byte-address width of data memory; addr >= 2**MEM_ADDR_BITS is out of range
// PORTS
//  pll_1_200MHz    in   1   sole clock, all state on rising edge
//  rst             in   1   synchronous reset, active-high
//  req_valid       in   1   request present
//  req_ready       out  1   controller can accept (IDLE only)
//  req_we          in   1   1=store, 0=load
//  req_funct3      in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data (SB uses [7:0], SH uses [15:0])
//  resp_valid      out  1   one-cycle pulse, request complete
//  resp_err        out  1   valid with resp_valid: access rejected
//  resp_rdata      out  32  extended load data; 0 for stores and errors
//  mem_read        out  1   to data memory
//  mem_write       out  1   to data memory
//  mem_address     out  32  {req_addr[31:2],2'b00} of captured request
//  mem_write_data  out  32  full or merged word; 0 when mem_write=0
//  mem_read_data   in   32  combinational read word from data memory
// BEHAVIOUR
//  - States: IDLE, LOAD, RMW_RD, WRITE, RESP. Reset -> IDLE; all registered outputs 0, req_ready=1.
//  - IDLE: req_ready=1. On req_valid: capture we/funct3/addr/wdata, then:
//      error -> RESP (err=1); load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
//  - Error = funct3 in {011,110,111}, or store with funct3[2]=1, or H/HU/SH with addr[0]=1,
//      or W with addr[1:0]!=0, or addr[31:MEM_ADDR_BITS]!=0. Errors never assert mem_read/mem_write.
//  - LOAD: mem_read=1; latch extracted lane of mem_read_data by addr[1:0], sign-extend (B,H) or
//      zero-extend (BU,HU) into resp_rdata -> RESP.
//  - RMW_RD: mem_read=1; latch mem_read_data into merge reg, replace byte lane addr[1:0] (SB)
//      or halfword lane addr[1] (SH) with req_wdata low bits -> WRITE.
//  - WRITE: mem_write=1, mem_write_data = req_wdata (SW) or merged word (SB/SH) -> RESP.
//  - RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE. req_valid here is not accepted.
//  - Latency accept-edge to resp_valid: LW/LB/SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
//    Throughput: next request accepted the cycle after resp_valid.
//  - mem_read/mem_write are decoded from state and forced 0 while rst=1: reset mid-access aborts it,
//    no partial RMW write occurs, state -> IDLE on that edge, no resp_valid issued.
//  - mem_read and mem_write are never 1 in the same cycle.
//  - resp_err, resp_rdata hold until next RESP; compare only when resp_valid=1.
// TESTING
//  1) SW addr 0x010 wdata 0xDEADBEEF, then LW 0x010 -> write seen 1 cycle, resp_rdata 0xDEADBEEF, err 0.
//  2) Word 0x11223344 @0x020; SB 0x023 wdata 0xAA -> mem holds 0xAA223344; LB 0x023 -> 0xFFFFFFAA; LBU -> 0x000000AA.
//  3) SH 0x022 wdata 0x8001 then LH 0x022 -> 0xFFFF8001; LHU -> 0x00008001; low half unchanged.
//  4) LW 0x006, SH 0x021, funct3 011, SB 0x1000 -> resp_err=1 one cycle after accept, no mem_read/mem_write.
//  5) SB issued, rst pulsed in RMW_RD or WRITE cycle -> no mem_write, no resp_valid, req_ready=1 after reset.
//  6) Back-to-back req_valid held high for 4 SB -> one accept per 4 cycles, ready low in RMW_RD/WRITE/RESP.

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer for a word-only data memory (combinational read,
// clocked write). Handles RV32I byte/halfword/word loads and stores.
// Sub-word stores use read-modify-write. Rejected accesses never touch memory.
module dmem_lsu_ctrl #(
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic        pll_1_200MHz,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic        req_err;
  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Classify the incoming request as illegal, misaligned or out of range
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = (req_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    if (req_we && req_funct3[2])
      req_err = 1'b1;
    if (req_addr[31:MEM_ADDR_BITS] != '0)
      req_err = 1'b1;
  end

  // Extract and extend the addressed lane of the read word for loads
  always_comb begin
    lane_word = mem_read_data >> {addr_q[1:0], 3'b000};
    load_data = mem_read_data;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b100:  load_data = {24'h000000, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b101:  load_data = {16'h0000, lane_word[15:0]};
      default: load_data = mem_read_data;
    endcase
  end

  // Merge store data into the read word for sub-word stores
  always_comb begin
    merged = mem_read_data;
    if (funct3_q[0])
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  // Sequencer: capture, memory access phases and one-cycle response
  always_ff @(posedge pll_1_200MHz) begin
    if (rst) begin
      state      <= S_IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            merge_q  <= req_wdata;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= S_RESP;
            end else if (!req_we) begin
              state <= S_LOAD;
            end else if (req_funct3 == 3'b010) begin
              state <= S_WRITE;
            end else begin
              state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_data;
          state      <= S_RESP;
        end
        S_RMW_RD: begin
          merge_q <= merged;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory strobes come straight from state so a reset cancels them at once
  always_comb begin
    req_ready      = (state == S_IDLE);
    mem_read       = !rst && ((state == S_LOAD) || (state == S_RMW_RD));
    mem_write      = !rst && (state == S_WRITE);
    mem_address    = {addr_q[31:2], 2'b00};
    mem_write_data = mem_write ? merge_q : '0;
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: byte-addressed reference model, directed cases
// and randomized load/store traffic against a word memory model.
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic        mem_init;

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.MEM_ADDR_BITS(12)) dut (
    .pll_1_200MHz  (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  function automatic logic [31:0] init_pattern(input int unsigned i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Word memory: combinational read, clocked write
  assign mem_read_data = mem[mem_address[11:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < 1024; i++) mem[i] <= init_pattern(i);
    end else if (mem_write) begin
      mem[mem_address[11:2]] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Continuous interface invariants
  always @(negedge clk) begin
    if (!mem_init) begin
      check("rw_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
      if (!mem_write) check("wdata_idle_zero", mem_write_data, 32'h0);
    end
  end

  // ---------------- reference model (byte-level view of memory) ----------
  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    if ((a % acc_size(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] b);
    logic [31:0] w;
    w = ref_mem[b[11:2]];
    return w[8*b[1:0] +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int unsigned sz;
    sz = acc_size(f3);
    v = '0;
    for (int unsigned i = 0; i < sz; i++) v[8*i +: 8] = ref_byte(a + i);
    if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b;
    for (int unsigned i = 0; i < acc_size(f3); i++) begin
      b = a + i;
      ref_mem[b[11:2]][8*b[1:0] +: 8] = d[8*i +: 8];
    end
  endtask

  // ---------------- one complete transaction ----------------
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata, output logic err);
    int unsigned w, lat, nrd, nwr, exp_lat, exp_rd, exp_wr;
    bit e;
    logic [31:0] exp_data;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check("ready_timeout", {31'b0, req_ready}, 32'h1);
    e = model_err(we, f3, a);
    exp_data = 32'h0;
    if (!e && !we) exp_data = model_load(f3, a);
    if (!e && we)  model_store(f3, a, d);
    exp_lat = e ? 1 : (we && f3 != 3'b010) ? 3 : 2;
    exp_rd  = (e || (we && f3 == 3'b010)) ? 0 : 1;
    exp_wr  = (!e && we) ? 1 : 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
    end while (!resp_valid && lat < 8);
    rdata = resp_rdata;
    err   = resp_err;
    check("latency",   lat, exp_lat);
    check("resp_err",  {31'b0, resp_err}, {31'b0, e});
    check("resp_data", resp_rdata, exp_data);
    check("n_reads",   nrd, exp_rd);
    check("n_writes",  nwr, exp_wr);
    if (!e && we) check("mem_word", mem[a[11:2]], ref_mem[a[11:2]]);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] ra, rdt;
  logic [2:0]  rf;
  bit          rwe;
  int unsigned acc, rdy_hi, nresp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_init = 1'b1;
    for (int unsigned i = 0; i < 1024; i++) ref_mem[i] = init_pattern(i);
    @(posedge clk); #1 mem_init = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {31'b0, req_ready},  32'h1);
    check("rst_rvalid", {31'b0, resp_valid}, 32'h0);
    check("rst_rerr",   {31'b0, resp_err},   32'h0);
    check("rst_rdata",  resp_rdata,          32'h0);
    check("rst_mrd",    {31'b0, mem_read},   32'h0);
    check("rst_mwr",    {31'b0, mem_write},  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // word store then load
    do_req(1, 3'b010, 32'h010, 32'hDEADBEEF, rd, er);
    do_req(0, 3'b010, 32'h010, 32'h0, rd, er);
    check("lw_const", rd, 32'hDEADBEEF);
    // byte store into known word, signed and unsigned byte loads
    do_req(1, 3'b010, 32'h020, 32'h11223344, rd, er);
    do_req(1, 3'b000, 32'h023, 32'h000000AA, rd, er);
    check("sb_mem_const", mem[8], 32'hAA223344);
    do_req(0, 3'b000, 32'h023, 32'h0, rd, er);
    check("lb_const", rd, 32'hFFFFFFAA);
    do_req(0, 3'b100, 32'h023, 32'h0, rd, er);
    check("lbu_const", rd, 32'h000000AA);
    // halfword store into upper half
    do_req(1, 3'b001, 32'h022, 32'h00008001, rd, er);
    do_req(0, 3'b001, 32'h022, 32'h0, rd, er);
    check("lh_const", rd, 32'hFFFF8001);
    do_req(0, 3'b101, 32'h022, 32'h0, rd, er);
    check("lhu_const", rd, 32'h00008001);
    do_req(0, 3'b101, 32'h020, 32'h0, rd, er);
    check("low_half_const", rd, 32'h00003344);
    // rejected accesses
    do_req(0, 3'b010, 32'h006, 32'h0, rd, er);
    check("err_lw_mis", {31'b0, er}, 32'h1);
    do_req(1, 3'b001, 32'h021, 32'h1234, rd, er);
    check("err_sh_mis", {31'b0, er}, 32'h1);
    do_req(0, 3'b011, 32'h000, 32'h0, rd, er);
    check("err_f3", {31'b0, er}, 32'h1);
    do_req(1, 3'b000, 32'h1000, 32'h55, rd, er);
    check("err_range", {31'b0, er}, 32'h1);
    do_req(1, 3'b100, 32'h004, 32'h55, rd, er);
    check("err_store_u", {31'b0, er}, 32'h1);

    // reset during the read phase and during the write phase of an SB
    for (int unsigned ph = 1; ph <= 2; ph++) begin
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h031; req_wdata = 32'h000000C3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int unsigned k = 0; k < ph; k++) @(negedge clk);
      if (ph == 1) check("pre_rst_rd", {31'b0, mem_read},  32'h1);
      else         check("pre_rst_wr", {31'b0, mem_write}, 32'h1);
      rst = 1'b1;
      #1;
      check("rst_kill_rd", {31'b0, mem_read},  32'h0);
      check("rst_kill_wr", {31'b0, mem_write}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_ready", {31'b0, req_ready}, 32'h1);
      nresp = 0;
      for (int unsigned k = 0; k < 4; k++) begin
        if (resp_valid) nresp++;
        if (mem_write)  nresp++;
        @(negedge clk);
      end
      check("post_rst_quiet", nresp, 0);
      check("rst_no_write", mem[12], ref_mem[12]);
    end

    // back-to-back SB with req_valid held high
    while (!req_ready) @(negedge clk);
    acc = 0; rdy_hi = 0; nresp = 0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid) nresp++;
      if (req_ready) begin
        rdy_hi++;
        acc++;
        req_addr  = 32'h040 + $urandom_range(0, 7);
        req_wdata = $urandom;
        model_store(3'b000, req_addr, req_wdata);
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc, 4);
    check("b2b_ready_hi", rdy_hi, 4);
    check("b2b_resps", nresp, 4);
    @(negedge clk);
    check("b2b_mem0", mem[16], ref_mem[16]);
    check("b2b_mem1", mem[17], ref_mem[17]);

    // randomized traffic
    for (int unsigned t = 0; t < 300; t++) begin
      rwe = $urandom_range(0, 1);
      rf  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      else if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 4095);
      else ra = $urandom_range(0, 63);
      rdt = $urandom;
      do_req(rwe, rf, ra, rdt, rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
